// File: rtl/spi_slave_regs.sv
// SPI mode-0 responder exposing a 2^ADDR_W x 8 register file to an SPI master,
// with a shared local port and a write-notification strobe for FPGA logic.
module spi_slave_regs #(
    parameter int          ADDR_W  = 5,
    parameter logic [7:0]  REG_RST = 8'h00
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              spi_sclk,
    input  logic              spi_ss_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [7:0]        status_in,
    input  logic [ADDR_W-1:0] loc_addr,
    output logic [7:0]        loc_rdata,
    input  logic              loc_we,
    input  logic [7:0]        loc_wdata,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              xfer_done
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
    state_t state_reg, state_next;

    // [0] metastable stage, [1] synchronized value, [2] previous synchronized sample
    logic [2:0]        sclk_sr_reg;
    logic [2:0]        ss_sr_reg;
    logic [1:0]        mosi_sr_reg;

    logic [7:0]        rx_sr_reg;
    logic [7:0]        tx_sr_reg;
    logic [2:0]        bitcnt_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              dir_reg;
    logic              wr_pend_reg;

    logic [7:0]        regs [DEPTH];

    logic              sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic [7:0]        rx_byte;
    logic              byte_done;
    logic              start, stop, cmd_done, data_done;
    logic              spi_we, rd_advance;
    logic [ADDR_W-1:0] cmd_addr, addr_inc;

    assign sclk_rise  = sclk_sr_reg[1] & ~sclk_sr_reg[2];
    assign sclk_fall  = ~sclk_sr_reg[1] & sclk_sr_reg[2];
    assign ss_fall    = ~ss_sr_reg[1] & ss_sr_reg[2];
    assign ss_rise    = ss_sr_reg[1] & ~ss_sr_reg[2];
    assign rx_byte    = {rx_sr_reg[6:0], mosi_sr_reg[1]};
    assign byte_done  = sclk_rise && (bitcnt_reg == 3'd7);
    assign cmd_addr   = rx_byte[3 +: ADDR_W];
    assign addr_inc   = addr_reg + ADDR_W'(1);
    assign spi_we     = data_done & dir_reg;
    assign rd_advance = data_done & ~dir_reg;
    assign loc_rdata  = regs[loc_addr];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sclk_sr_reg <= 3'b000;
            ss_sr_reg   <= 3'b111;
            mosi_sr_reg <= 2'b00;
            state_reg   <= IDLE;
        end else begin
            sclk_sr_reg <= {sclk_sr_reg[1:0], spi_sclk};
            ss_sr_reg   <= {ss_sr_reg[1:0], spi_ss_n};
            mosi_sr_reg <= {mosi_sr_reg[0], spi_mosi};
            state_reg   <= state_next;
        end
    end

    // A select release always takes priority over a byte completing in the same cycle.
    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        stop       = 1'b0;
        cmd_done   = 1'b0;
        data_done  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ss_fall) begin
                    start      = 1'b1;
                    state_next = CMD;
                end
            end
            CMD: begin
                if (ss_rise) begin
                    stop       = 1'b1;
                    state_next = IDLE;
                end else if (byte_done) begin
                    cmd_done   = 1'b1;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (ss_rise) begin
                    stop       = 1'b1;
                    state_next = IDLE;
                end else if (byte_done) begin
                    data_done  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            rx_sr_reg   <= 8'h00;
            tx_sr_reg   <= 8'h00;
            bitcnt_reg  <= 3'd0;
            addr_reg    <= '0;
            dir_reg     <= 1'b0;
            wr_pend_reg <= 1'b0;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= 8'h00;
            xfer_done   <= 1'b0;
        end else begin
            // Strobe trails the regfile update by a cycle so regs[wr_addr] already holds wr_data.
            wr_pend_reg <= spi_we;
            wr_strobe   <= wr_pend_reg;
            xfer_done   <= stop;
            if (start) begin
                spi_miso    <= status_in[7];
                tx_sr_reg   <= {status_in[6:0], 1'b0};
                bitcnt_reg  <= 3'd0;
                spi_miso_oe <= 1'b1;
            end else if (stop) begin
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
                bitcnt_reg  <= 3'd0;
            end else if (state_reg != IDLE) begin
                if (sclk_rise) begin
                    rx_sr_reg  <= rx_byte;
                    bitcnt_reg <= bitcnt_reg + 3'd1;
                end
                if (sclk_fall) begin
                    spi_miso  <= tx_sr_reg[7];
                    tx_sr_reg <= {tx_sr_reg[6:0], 1'b0};
                end
                if (cmd_done) begin
                    addr_reg  <= cmd_addr;
                    dir_reg   <= rx_byte[1];
                    tx_sr_reg <= rx_byte[1] ? 8'h00 : regs[cmd_addr];
                end
                if (spi_we) begin
                    wr_addr  <= addr_reg;
                    wr_data  <= rx_byte;
                    addr_reg <= addr_inc;
                end
                if (rd_advance) begin
                    addr_reg  <= addr_inc;
                    tx_sr_reg <= regs[addr_inc];
                end
            end
        end
    end

    // Flop-based file: the local read port is combinational, so no RAM macro fits.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
            always_ff @(posedge Clk) begin
                if (Reset)
                    regs[gi] <= REG_RST;
                else if (spi_we && (addr_reg == ADDR_W'(gi)))
                    regs[gi] <= rx_byte;
                else if (loc_we && (loc_addr == ADDR_W'(gi)))
                    regs[gi] <= loc_wdata;
            end
        end
    endgenerate

endmodule

// File: tb/tb_spi_slave_regs.sv
// Randomized bench for spi_slave_regs: a bit-level SPI master plus an array model of
// the register file predicting MISO bytes, write strobes and local readback.
module tb_spi_slave_regs;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              spi_sclk, spi_ss_n, spi_mosi;
    logic              spi_miso, spi_miso_oe;
    logic [7:0]        status_in;
    logic [ADDR_W-1:0] loc_addr;
    logic [7:0]        loc_rdata;
    logic              loc_we;
    logic [7:0]        loc_wdata;
    logic              wr_strobe;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              xfer_done;

    spi_slave_regs #(.ADDR_W(ADDR_W), .REG_RST(8'h00)) dut (
        .Clk(Clk), .Reset(Reset),
        .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .status_in(status_in),
        .loc_addr(loc_addr), .loc_rdata(loc_rdata), .loc_we(loc_we), .loc_wdata(loc_wdata),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .xfer_done(xfer_done)
    );

    always #5 Clk = ~Clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          pcnt = 0;
    int          rise_p = 0;
    int          strobe_p = 0;
    int          done_cnt = 0;
    logic [15:0] obs_q[$];
    logic [15:0] exp_q[$];
    logic [7:0]  model [DEPTH];
    logic [7:0]  tx_buf [4];

    always @(posedge Clk) pcnt <= pcnt + 1;

    always @(negedge Clk) begin
        if (wr_strobe) begin
            obs_q.push_back({3'b000, wr_addr, wr_data});
            strobe_p = pcnt;
        end
        if (xfer_done) done_cnt++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Mode 0: MOSI set while SCLK low, both sides sample on the rising edge.
    task automatic spi_byte(input logic [7:0] tx, input int nbits, input bit do_we,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            repeat (5) @(negedge Clk);
            spi_sclk = 1'b1;
            rx[7-i]  = spi_miso;
            rise_p   = pcnt;
            if (do_we && i == 7) begin
                // Byte completes on the 3rd Clk edge after the pin edge (2-FF sync + edge detect).
                repeat (2) @(posedge Clk);
                @(negedge Clk) loc_we = 1'b1;
                @(negedge Clk) loc_we = 1'b0;
            end
            repeat (5) @(negedge Clk);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic loc_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        @(negedge Clk);
        loc_addr  = a;
        loc_wdata = d;
        loc_we    = 1'b1;
        @(negedge Clk);
        loc_we    = 1'b0;
        model[a]  = d;
        $display("local write addr=%0d data=%02h", a, d);
    endtask

    task automatic check_regs(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge Clk);
            loc_addr = ADDR_W'(a);
            #1;
            chk(tag, loc_rdata, model[a]);
        end
    endtask

    // One selected transfer: command byte, nbytes data bytes from tx_buf, the last one
    // possibly truncated to last_bits; we_byte selects a byte to collide a loc_we with.
    task automatic do_xfer(input logic [7:0] status, input logic [7:0] cmd, input int nbytes,
                           input int last_bits, input int we_byte);
        logic [7:0]        rx;
        logic [ADDR_W-1:0] a;
        bit                wr;
        int                bits;
        obs_q.delete();
        exp_q.delete();
        done_cnt  = 0;
        status_in = status;
        spi_ss_n  = 1'b0;
        repeat (6) @(negedge Clk);
        chk("oe_active", spi_miso_oe, 1'b1);
        spi_byte(cmd, 8, 1'b0, rx);
        chk("status", rx, status);
        a  = cmd[7:3];
        wr = cmd[1];
        for (int j = 0; j < nbytes; j++) begin
            bits = (j == nbytes - 1) ? last_bits : 8;
            spi_byte(tx_buf[j], bits, (j == we_byte), rx);
            if (bits == 8) begin
                if (wr) begin
                    model[a] = tx_buf[j];
                    exp_q.push_back({3'b000, a, tx_buf[j]});
                end else begin
                    chk("rdata", rx, model[a]);
                end
                a = a + 1'b1;
            end
        end
        repeat (5) @(negedge Clk);
        spi_ss_n = 1'b1;
        repeat (8) @(negedge Clk);
        chk("nstrobe", obs_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
            chk("strobe", obs_q[k], exp_q[k]);
        chk("xfer_done", done_cnt, 1);
        chk("oe_idle", spi_miso_oe, 1'b0);
        $display("xfer cmd=%02h status=%02h bytes=%0d last_bits=%0d strobes=%0d",
                 cmd, status, nbytes, last_bits, obs_q.size());
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] cmd;
        int         nb;
        Reset     = 1'b1;
        spi_sclk  = 1'b0;
        spi_ss_n  = 1'b1;
        spi_mosi  = 1'b0;
        status_in = 8'h00;
        loc_addr  = '0;
        loc_we    = 1'b0;
        loc_wdata = 8'h00;
        for (int a = 0; a < DEPTH; a++) model[a] = 8'h00;
        repeat (4) @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        chk("rst_oe", spi_miso_oe, 1'b0);
        chk("rst_miso", spi_miso, 1'b0);
        chk("rst_strobe", wr_strobe, 1'b0);
        chk("rst_done", xfer_done, 1'b0);
        chk("rst_wr", {wr_addr, wr_data}, '0);
        check_regs("rst_reg");

        // Single write with status readback and latency measurement
        tx_buf[0] = 8'h3C;
        do_xfer(8'hA5, 8'h12, 1, 8, -1);
        chk("strobe_lat", strobe_p - rise_p, 4);

        // Burst write wrapping from 31 to 0
        tx_buf[0] = 8'h11;
        tx_buf[1] = 8'h22;
        do_xfer(8'h5A, 8'hFA, 2, 8, -1);

        // Burst read of locally written data
        loc_write(4, 8'h77);
        loc_write(5, 8'h88);
        tx_buf[0] = 8'h00;
        tx_buf[1] = 8'hFF;
        do_xfer(8'h3C, 8'h20, 2, 8, -1);
        check_regs("reg_a");

        // Aborted write byte after 5 bits, then a normal transfer
        tx_buf[0] = 8'hAA;
        do_xfer(8'h81, 8'h32, 1, 5, -1);
        tx_buf[0] = 8'h5E;
        do_xfer(8'h42, 8'h32, 1, 8, -1);

        // loc_we to the same address in the commit cycle: SPI wins
        loc_addr  = 5'd2;
        loc_wdata = 8'h55;
        tx_buf[0] = 8'h99;
        do_xfer(8'h00, 8'h12, 1, 8, 0);
        check_regs("reg_b");

        // Randomized transfers interleaved with local writes
        for (int t = 0; t < 24; t++) begin
            for (int w = 0; w < $urandom_range(0, 2); w++)
                loc_write(ADDR_W'($urandom), 8'($urandom));
            cmd = 8'($urandom);
            nb  = $urandom_range(1, 3);
            for (int j = 0; j < 4; j++) tx_buf[j] = 8'($urandom);
            do_xfer(8'($urandom), cmd, nb, 8, -1);
        end
        check_regs("reg_rand");

        // Reset in the middle of a write data byte
        obs_q.delete();
        spi_ss_n = 1'b0;
        repeat (6) @(negedge Clk);
        spi_byte(8'h12, 8, 1'b0, rx);
        spi_byte(8'h44, 4, 1'b0, rx);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        chk("midrst_oe", spi_miso_oe, 1'b0);
        spi_ss_n = 1'b1;
        spi_sclk = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        repeat (4) @(negedge Clk);
        chk("midrst_strobe", obs_q.size(), 0);
        for (int a = 0; a < DEPTH; a++) model[a] = 8'h00;
        check_regs("midrst_reg");
        $display("mid-byte reset applied");

        tx_buf[0] = 8'hC3;
        do_xfer(8'h7E, 8'h4A, 1, 8, -1);
        check_regs("reg_final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
